// File: rtl/axi_lite_slave_regs_pkg.sv
// Shared definitions for the Splitter S00_AXI control-port register slave:
// response codes, register-index decode constants, FSM state types and the
// byte-strobe merge helper used when a write commits.
package splitter_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam int         REG_IDX_LSB = 2;
    localparam int         NUM_REGS    = 4;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wrState_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rdState_t;

    // Replace only the byte lanes whose strobe bit is set; the rest keep oldVal.
    function automatic logic [31:0] strbMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

endpackage

// File: rtl/axi_lite_slave_regs_wr_ctrl.sv
// Write-channel controller: accepts the AW and W beats in either order (or
// together), holds whichever arrives first, and reports a single commit in the
// cycle the second beat is accepted. BVALID follows one cycle later and is held
// until the master takes it.
module axi_lite_wr_ctrl
    import splitter_axi_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  awIdx_i,
    input  logic        awValid_i,
    output logic        awReady_o,
    input  logic [31:0] wData_i,
    input  logic [3:0]  wStrb_i,
    input  logic        wValid_i,
    output logic        wReady_o,
    output logic        bValid_o,
    input  logic        bReady_i,
    output logic        commit_o,
    output logic [1:0]  commitIdx_o,
    output logic [31:0] commitData_o,
    output logic [3:0]  commitStrb_o
);

    wrState_t    wrState_q;
    logic        awReady_q;
    logic        wReady_q;
    logic        bValid_q;
    logic [1:0]  idx_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;

    logic        awHs;
    logic        wHs;

    assign awHs = awValid_i && awReady_q;
    assign wHs  = wValid_i  && wReady_q;

    // The commit fires on the edge of the second beat; fields come from the
    // live bus for the beat arriving now and from the holding regs otherwise.
    always_comb begin
        commit_o     = 1'b0;
        commitIdx_o  = idx_q;
        commitData_o = data_q;
        commitStrb_o = strb_q;
        case (wrState_q)
            W_IDLE: begin
                if (awHs && wHs) begin
                    commit_o     = 1'b1;
                    commitIdx_o  = awIdx_i;
                    commitData_o = wData_i;
                    commitStrb_o = wStrb_i;
                end
            end
            W_HAVE_ADDR: begin
                if (wHs) begin
                    commit_o     = 1'b1;
                    commitData_o = wData_i;
                    commitStrb_o = wStrb_i;
                end
            end
            W_HAVE_DATA: begin
                if (awHs) begin
                    commit_o    = 1'b1;
                    commitIdx_o = awIdx_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Write FSM with registered READY/VALID. Returning to W_IDLE leaves both
    // READYs low for one cycle, giving one write per three cycles back to back.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrState_q <= W_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            case (wrState_q)
                W_IDLE: begin
                    if (awHs && wHs) begin
                        wrState_q <= W_RESP;
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b0;
                        bValid_q  <= 1'b1;
                    end else if (awHs) begin
                        idx_q     <= awIdx_i;
                        wrState_q <= W_HAVE_ADDR;
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b1;
                    end else if (wHs) begin
                        data_q    <= wData_i;
                        strb_q    <= wStrb_i;
                        wrState_q <= W_HAVE_DATA;
                        awReady_q <= 1'b1;
                        wReady_q  <= 1'b0;
                    end else begin
                        awReady_q <= 1'b1;
                        wReady_q  <= 1'b1;
                    end
                end
                W_HAVE_ADDR: begin
                    if (wHs) begin
                        wrState_q <= W_RESP;
                        wReady_q  <= 1'b0;
                        bValid_q  <= 1'b1;
                    end
                end
                W_HAVE_DATA: begin
                    if (awHs) begin
                        wrState_q <= W_RESP;
                        awReady_q <= 1'b0;
                        bValid_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bValid_q && bReady_i) begin
                        wrState_q <= W_IDLE;
                        bValid_q  <= 1'b0;
                    end
                end
                default: begin
                    wrState_q <= W_IDLE;
                    awReady_q <= 1'b0;
                    wReady_q  <= 1'b0;
                    bValid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign awReady_o = awReady_q;
    assign wReady_o  = wReady_q;
    assign bValid_o  = bValid_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave for the Splitter control port: four 32-bit R/W registers
// decoded by address bits [3:2], each with a one-cycle update pulse. The write
// path lives in axi_lite_wr_ctrl; the read FSM is kept here next to the regs.
module axi_lite_slave_regs
    import splitter_axi_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_VAL          = 32'h0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     reg0_o,
    output logic [31:0]                     reg1_o,
    output logic [31:0]                     reg2_o,
    output logic [31:0]                     reg3_o,
    output logic [3:0]                      reg_wr_pulse_o
);

    logic [31:0] regs_q [NUM_REGS];
    logic [3:0]  wrPulse_q;
    rdState_t    rdState_q;
    logic        arReady_q;
    logic        rValid_q;
    logic [31:0] rData_q;

    logic [1:0]  awIdx;
    logic [1:0]  arIdx;
    logic        commit;
    logic [1:0]  commitIdx;
    logic [31:0] commitData;
    logic [3:0]  commitStrb;
    logic        unusedBits;

    // Only the register-select bits matter; byte offset, aliasing upper bits
    // and the PROT fields are deliberately ignored.
    assign awIdx      = S_AXI_AWADDR[REG_IDX_LSB +: 2];
    assign arIdx      = S_AXI_ARADDR[REG_IDX_LSB +: 2];
    assign unusedBits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT, S_AXI_ARPROT};

    axi_lite_wr_ctrl uWrCtrl (
        .clk_i        (S_AXI_ACLK),
        .reset_i      (S_AXI_ARESET),
        .awIdx_i      (awIdx),
        .awValid_i    (S_AXI_AWVALID),
        .awReady_o    (S_AXI_AWREADY),
        .wData_i      (S_AXI_WDATA),
        .wStrb_i      (S_AXI_WSTRB),
        .wValid_i     (S_AXI_WVALID),
        .wReady_o     (S_AXI_WREADY),
        .bValid_o     (S_AXI_BVALID),
        .bReady_i     (S_AXI_BREADY),
        .commit_o     (commit),
        .commitIdx_o  (commitIdx),
        .commitData_o (commitData),
        .commitStrb_o (commitStrb)
    );

    // Register file update: merge enabled byte lanes on commit and raise the
    // matching pulse bit for exactly the following cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wrPulse_q <= '0;
        end else begin
            wrPulse_q <= '0;
            if (commit) begin
                regs_q[commitIdx] <= strbMerge(regs_q[commitIdx], commitData, commitStrb);
                wrPulse_q         <= 4'b0001 << commitIdx;
            end
        end
    end

    // Read FSM: sample the register array on the AR handshake, so a write that
    // commits on that same edge is not yet visible to this read.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdState_q <= R_IDLE;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
        end else begin
            case (rdState_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arReady_q) begin
                        rData_q   <= regs_q[arIdx];
                        arReady_q <= 1'b0;
                        rValid_q  <= 1'b1;
                        rdState_q <= R_DATA;
                    end else begin
                        arReady_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rValid_q  <= 1'b0;
                        rdState_q <= R_IDLE;
                    end
                end
                default: begin
                    rdState_q <= R_IDLE;
                    arReady_q <= 1'b0;
                    rValid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_ARREADY  = arReady_q;
    assign S_AXI_RVALID   = rValid_q;
    assign S_AXI_RDATA    = rData_q;
    assign S_AXI_RRESP    = RESP_OKAY;
    assign S_AXI_BRESP    = RESP_OKAY;
    assign reg0_o         = regs_q[0];
    assign reg1_o         = regs_q[1];
    assign reg2_o         = regs_q[2];
    assign reg3_o         = regs_q[3];
    assign reg_wr_pulse_o = wrPulse_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed scenarios followed by random traffic.
// Drivers push expected B/R responses and update pulses into queues; monitor
// processes pop and compare whenever the DUT presents a transfer.
module tb_axi_lite_slave_regs;

    localparam int          LIMIT     = 64;
    localparam logic [31:0] RESET_VAL = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awAddr;
    logic [2:0]  awProt;
    logic        awValid;
    logic        awReady;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic        wValid;
    logic        wReady;
    logic [1:0]  bResp;
    logic        bValid;
    logic        bReady;
    logic [3:0]  arAddr;
    logic [2:0]  arProt;
    logic        arValid;
    logic        arReady;
    logic [31:0] rData;
    logic [1:0]  rResp;
    logic        rValid;
    logic        rReady;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic [3:0]  wrPulse;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [4];
    logic [1:0]  expB [$];
    logic [31:0] expR [$];
    int          expPulseIdx [$];
    logic [31:0] expPulseVal [$];

    always #5 clk = ~clk;

    axi_lite_slave_regs dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .S_AXI_AWADDR   (awAddr),
        .S_AXI_AWPROT   (awProt),
        .S_AXI_AWVALID  (awValid),
        .S_AXI_AWREADY  (awReady),
        .S_AXI_WDATA    (wData),
        .S_AXI_WSTRB    (wStrb),
        .S_AXI_WVALID   (wValid),
        .S_AXI_WREADY   (wReady),
        .S_AXI_BRESP    (bResp),
        .S_AXI_BVALID   (bValid),
        .S_AXI_BREADY   (bReady),
        .S_AXI_ARADDR   (arAddr),
        .S_AXI_ARPROT   (arProt),
        .S_AXI_ARVALID  (arValid),
        .S_AXI_ARREADY  (arReady),
        .S_AXI_RDATA    (rData),
        .S_AXI_RRESP    (rResp),
        .S_AXI_RVALID   (rValid),
        .S_AXI_RREADY   (rReady),
        .reg0_o         (reg0),
        .reg1_o         (reg1),
        .reg2_o         (reg2),
        .reg3_o         (reg3),
        .reg_wr_pulse_o (wrPulse)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s (event not expected or never seen)", name);
    endtask

    function automatic logic [31:0] regByIdx(input int i);
        case (i)
            0:       return reg0;
            1:       return reg1;
            2:       return reg2;
            default: return reg3;
        endcase
    endfunction

    task automatic checkRegs();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reg%0d_value", i), regByIdx(i), model[i]);
        end
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap delays the later beat.
    task automatic writeTxn(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int bDelay);
        int awStart;
        int wStart;
        int k;
        int idx;
        bit awDone;
        bit wDone;
        bit awHs;
        bit wHs;
        bit bvBefore;
        awStart  = (order == 2) ? gap + 1 : 0;
        wStart   = (order == 1) ? gap + 1 : 0;
        idx      = int'(addr[3:2]);
        awDone   = 1'b0;
        wDone    = 1'b0;
        bvBefore = 1'b0;
        k        = 0;
        while (!(awDone && wDone) && k < LIMIT) begin
            if (k == awStart && !awDone) begin
                awValid = 1'b1;
                awAddr  = addr;
            end
            if (k == wStart && !wDone) begin
                wValid = 1'b1;
                wData  = data;
                wStrb  = strb;
            end
            @(negedge clk);
            awHs     = awValid && awReady;
            wHs      = wValid && wReady;
            bvBefore = bValid;
            @(posedge clk);
            #1;
            if (awHs) begin
                awDone  = 1'b1;
                awValid = 1'b0;
            end
            if (wHs) begin
                wDone  = 1'b1;
                wValid = 1'b0;
            end
            k++;
        end
        if (!(awDone && wDone)) begin
            awValid = 1'b0;
            wValid  = 1'b0;
            failNow("write_handshake_timeout");
            return;
        end
        checkOutput("b_low_at_commit", 32'(bvBefore), 0);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        expB.push_back(2'b00);
        expPulseIdx.push_back(idx);
        expPulseVal.push_back(model[idx]);
        bReady = (bDelay == 0);
        @(negedge clk);
        checkOutput("b_latency", 32'(bValid), 1);
        for (int i = 0; i < bDelay; i++) begin
            checkOutput("b_hold_valid", 32'(bValid), 1);
            checkOutput("b_hold_awready", 32'(awReady), 0);
            checkOutput("b_hold_wready", 32'(wReady), 0);
            @(posedge clk);
            #1;
            if (i == bDelay - 1) bReady = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bReady = 1'b0;
    endtask

    task automatic readTxn(input logic [3:0] addr, input int rDelay);
        logic [31:0] exp;
        bit hs;
        int k;
        exp     = model[int'(addr[3:2])];
        arValid = 1'b1;
        arAddr  = addr;
        hs      = 1'b0;
        k       = 0;
        while (!hs && k < LIMIT) begin
            @(negedge clk);
            hs = arValid && arReady;
            @(posedge clk);
            #1;
            k++;
        end
        arValid = 1'b0;
        if (!hs) begin
            failNow("read_handshake_timeout");
            return;
        end
        expR.push_back(exp);
        rReady = (rDelay == 0);
        @(negedge clk);
        checkOutput("r_latency", 32'(rValid), 1);
        for (int i = 0; i < rDelay; i++) begin
            checkOutput("r_hold_valid", 32'(rValid), 1);
            checkOutput("r_hold_data", rData, exp);
            checkOutput("r_hold_arready", 32'(arReady), 0);
            @(posedge clk);
            #1;
            if (i == rDelay - 1) rReady = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rReady = 1'b0;
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [3:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int order, input int gap, input int dly);
        if (isWrite) writeTxn(addr, data, strb, order, gap, dly);
        else         readTxn(addr, dly);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitReady(input bit isAw, output bit hs);
        int k;
        hs = 1'b0;
        k  = 0;
        while (!hs && k < LIMIT) begin
            @(negedge clk);
            hs = isAw ? awReady : arReady;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // B-channel monitor: every accepted response must match a queued write.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bValid && bReady) begin
                if (expB.size() == 0) failNow("b_unexpected");
                else begin
                    e = expB.pop_front();
                    checkOutput("bresp", 32'(bResp), 32'(e));
                end
            end
        end
    end

    // R-channel monitor: every accepted read must match the queued model value.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rValid && rReady) begin
                if (expR.size() == 0) failNow("r_unexpected");
                else begin
                    e = expR.pop_front();
                    checkOutput("rdata", rData, e);
                    checkOutput("rresp", 32'(rResp), 0);
                end
            end
        end
    end

    // Update-pulse monitor: each nonzero cycle consumes one queued commit, so a
    // pulse lasting two cycles or firing with no write shows up as a failure.
    initial begin
        int          pIdx;
        logic [31:0] pVal;
        logic [3:0]  ep;
        forever begin
            @(negedge clk);
            if (!rst && wrPulse != 4'b0000) begin
                if (expPulseIdx.size() == 0) failNow("pulse_unexpected");
                else begin
                    pIdx = expPulseIdx.pop_front();
                    pVal = expPulseVal.pop_front();
                    ep   = 4'b0001 << pIdx;
                    checkOutput("wr_pulse", 32'(wrPulse), 32'(ep));
                    checkOutput("pulse_reg_value", regByIdx(pIdx), pVal);
                    checkOutput("pulse_with_bvalid", 32'(bValid), 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          hs;
        bit          isW;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;

        rst     = 1'b1;
        awAddr  = '0;
        awProt  = '0;
        awValid = 1'b0;
        wData   = '0;
        wStrb   = '0;
        wValid  = 1'b0;
        bReady  = 1'b0;
        arAddr  = '0;
        arProt  = '0;
        arValid = 1'b0;
        rReady  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = RESET_VAL;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_awready", 32'(awReady), 0);
        checkOutput("rst_wready", 32'(wReady), 0);
        checkOutput("rst_bvalid", 32'(bValid), 0);
        checkOutput("rst_arready", 32'(arReady), 0);
        checkOutput("rst_rvalid", 32'(rValid), 0);
        checkOutput("rst_rdata", rData, 0);
        checkOutput("rst_pulse", 32'(wrPulse), 0);
        checkRegs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] basic write/read of reg0");
        applyStimulus(1'b1, 4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0);
        checkOutput("reg0_written", reg0, 32'h0101FFFF);
        applyStimulus(1'b0, 4'h0, '0, '0, 0, 0, 0);

        $display("[TB] sequential writes to reg1..reg3");
        applyStimulus(1'b1, 4'h4, 32'hABCD0001, 4'hF, 0, 0, 0);
        applyStimulus(1'b0, 4'h4, '0, '0, 0, 0, 0);
        applyStimulus(1'b1, 4'h8, 32'hDEAD0011, 4'hF, 0, 0, 0);
        applyStimulus(1'b0, 4'h8, '0, '0, 0, 0, 0);
        applyStimulus(1'b1, 4'hC, 32'hBEEF0011, 4'hF, 0, 0, 0);
        applyStimulus(1'b0, 4'hC, '0, '0, 0, 0, 0);
        checkRegs();

        $display("[TB] beat ordering and partial strobe on reg1");
        applyStimulus(1'b1, 4'h4, 32'h5555AAAA, 4'hF, 2, 1, 0);
        checkOutput("reg1_w_first", reg1, 32'h5555AAAA);
        applyStimulus(1'b1, 4'h4, 32'hABCD0001, 4'hF, 1, 1, 0);
        checkOutput("reg1_aw_first", reg1, 32'hABCD0001);
        applyStimulus(1'b1, 4'h4, 32'h11223344, 4'b0101, 0, 0, 0);
        checkOutput("reg1_partial", reg1, 32'hAB220044);
        applyStimulus(1'b0, 4'h5, '0, '0, 0, 0, 0);
        checkRegs();

        $display("[TB] response back-pressure");
        applyStimulus(1'b1, 4'h8, 32'hDEAD0011, 4'hF, 0, 0, 5);
        applyStimulus(1'b0, 4'h8, '0, '0, 0, 0, 5);

        $display("[TB] read and write of reg2 on the same edge");
        idleCycles(3);
        fork
            writeTxn(4'h8, 32'h12345678, 4'hF, 0, 0, 0);
            readTxn(4'h8, 0);
        join
        applyStimulus(1'b0, 4'h8, '0, '0, 0, 0, 0);
        checkOutput("reg2_after_race", reg2, 32'h12345678);

        $display("[TB] reset during W_HAVE_ADDR and R_DATA");
        idleCycles(3);
        awValid = 1'b1;
        awAddr  = 4'h4;
        waitReady(1'b1, hs);
        awValid = 1'b0;
        checkOutput("abort_aw_accepted", 32'(hs), 1);
        arValid = 1'b1;
        arAddr  = 4'h0;
        waitReady(1'b0, hs);
        arValid = 1'b0;
        checkOutput("abort_ar_accepted", 32'(hs), 1);
        @(negedge clk);
        checkOutput("pre_rst_rvalid", 32'(rValid), 1);
        checkOutput("pre_rst_wready", 32'(wReady), 1);
        checkOutput("pre_rst_awready", 32'(awReady), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = RESET_VAL;
        @(negedge clk);
        checkOutput("abort_awready", 32'(awReady), 0);
        checkOutput("abort_wready", 32'(wReady), 0);
        checkOutput("abort_arready", 32'(arReady), 0);
        checkOutput("abort_rvalid", 32'(rValid), 0);
        checkOutput("abort_bvalid", 32'(bValid), 0);
        checkOutput("abort_pulse", 32'(wrPulse), 0);
        checkRegs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_no_bvalid", 32'(bValid), 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'h4, 32'hCAFE1234, 4'hF, 2, 0, 0);
        checkRegs();

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            isW  = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            data = $urandom();
            strb = 4'($urandom_range(0, 15));
            applyStimulus(isW, addr, data, strb, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            checkRegs();
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(5);
        checkOutput("b_queue_drained", expB.size(), 0);
        checkOutput("r_queue_drained", expR.size(), 0);
        checkOutput("pulse_queue_drained", expPulseIdx.size(), 0);
        checkRegs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder (slave end) for the Splitter IP's S00_AXI control port.
- Answers the write/read bursts issued by the AXI4-Lite master BFM and by the PS.
- Holds four 32-bit read/write control registers and exposes them to the Splitter datapath, with a one-cycle update pulse per register.
- Write and read channels are independent; one outstanding transaction per direction.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- RESET_VAL, 32'h0, reset value of all four registers.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- reg0_o..reg3_o  out  32 each  register contents.
- reg_wr_pulse_o  out  4  one-hot pulse; bit n is high for 1 cycle when regn is written.

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset is synchronous and active-high: S_AXI_ARESET sampled high at a rising edge resets everything.
- Reset values:
  - All READY and VALID outputs = 0.
  - BRESP and RRESP = 0; RDATA = 0.
  - reg0..reg3 = RESET_VAL; reg_wr_pulse_o = 0.
  - Both FSMs return to IDLE.
  - Reset mid-transaction abandons it with no register update and no response.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY = WREADY = 1.
    - AW and W accepted in the same cycle -> W_RESP.
    - AW only -> latch address, W_HAVE_ADDR (AWREADY = 0, WREADY = 1).
    - W only -> latch data and strobe, W_HAVE_DATA (WREADY = 0, AWREADY = 1).
  - W_HAVE_ADDR: waits for the W beat; W_HAVE_DATA: waits for the AW beat. Either completion -> W_RESP.
  - Commit: register update happens on the edge where the second of AW/W completes.
    - Byte lane b is written only if WSTRB[b] = 1.
    - reg_wr_pulse_o[idx] is high on the following cycle, aligned with BVALID rising.
  - W_RESP: BVALID = 1, AWREADY = WREADY = 0; leave to W_IDLE on BVALID && BREADY. BVALID is held until accepted.
  - Write latency: BVALID asserts 1 cycle after the second handshake. Back-to-back throughput is one write per 3 cycles with BREADY tied high.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1. On ARVALID, capture RDATA = reg[ARADDR[3:2]] and go to R_DATA. RVALID asserts the next cycle.
  - R_DATA: ARREADY = 0, RVALID = 1. RDATA is stable until RREADY; then go to R_IDLE and clear RVALID.
- Simultaneous events:
  - A read and a write to the same register in the same cycle: the read returns the pre-write value (reads sample before commit).
  - Reads and writes otherwise proceed concurrently with no mutual blocking.
- Addressing: all 2^C_S_AXI_ADDR_WIDTH addresses decode to one of the 4 registers by bits [3:2]. Address 0x10 aliases 0x0 when the width is larger than 4. No SLVERR or DECERR is ever returned.
- Protocol rules: no combinational path from any VALID input to any READY output (READY is registered). Every output is driven from a flop.

Decomposition:
- Package splitter_axi_pkg holds:
  - RESP_OKAY = 2'b00.
  - REG_IDX_LSB = 2, NUM_REGS = 4.
  - Write-FSM and read-FSM state enums.
  - The byte-strobe merge function: new = (old & ~mask) | (wdata & mask), where mask expands WSTRB to bytes.
- One natural sub-module: axi_lite_wr_ctrl, containing the write FSM and address/data latching, emitting commit/idx/data/strb. The read FSM stays inline.

Test Plan:
- Write 0x0101FFFF @0x0, read @0x0 -> BRESP = 0, RDATA = 0x0101FFFF, RRESP = 0, reg0_o = 0x0101FFFF, reg_wr_pulse_o = 4'b0001 for exactly 1 cycle.
- Sequential write/read of 0xABCD0001 @0x4, 0xDEAD0011 @0x8, 0xBEEF0011 @0xC -> each read returns its written value; the other registers are unchanged.
- Ordering and partial strobe:
  - W beat two cycles before AW, then AW before W, to reg1 -> both commit; BVALID asserts exactly 1 cycle after the later handshake.
  - WSTRB = 4'b0101 with data 0x11223344 onto 0xABCD0001 -> reg1 = 0xAB220044.
- Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID and RDATA are held stable, no new AW/AR is accepted, and the transfer completes on release.
- Read of reg2 issued in the same cycle as a write commit to reg2 (old 0xDEAD0011, new 0x12345678) -> RDATA = 0xDEAD0011; a subsequent read returns 0x12345678.
- Assert S_AXI_ARESET while in W_HAVE_ADDR and while in R_DATA -> next cycle all VALID/READY = 0, registers = RESET_VAL, no BVALID ever issued for the aborted write.
